jk_bank_driver: RTL and testbench

- Controller that drives a bank of WIDTH JK flip-flops, each with ports clk, reset, j, k, q, to a requested target pattern.
- Takes a start/target request and derives per-bit J/K from the JK excitation table using the bank's q feedback.
- Issues one J/K update pulse, then reads back q to confirm the load, retrying on mismatch.
- Sits between control logic (FSM/switch decoder) and a jk_ff array on the Basys3 designs.

---
 rtl/jk_bank_driver.sv | 142 ++++++++++++++
 tb/tb_jk_bank_driver.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: loads a bank of WIDTH JK flip-flops with a requested pattern.
//
// The controller latches a target when start is accepted, drives one J/K update pulse
// derived from the JK excitation table and the bank's q feedback, then reads q back.
// On a mismatch it retries up to MAX_RETRY extra times before raising the sticky err flag.
//
// Ports:
//   clk     in   system clock, all logic on posedge
//   reset   in   synchronous active-low reset
//   start   in   load request, sampled only while idle
//   target  in   desired q pattern, latched when start is accepted
//   q_fb    in   q outputs of the JK bank
//   j, k    out  registered J/K inputs to the bank
//   busy    out  high from start acceptance until done
//   done    out  one-cycle pulse at the end of an operation (success or error)
//   err     out  sticky readback-failure flag, cleared by the next accepted start
//
// Build option: define JK_BANK_DRIVER_TOGGLE_EN to drive changing bits with j=k=1 (toggle)
// instead of the default set/reset encoding. Timing is identical in both builds.

module jk_bank_driver #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);

  typedef enum logic [1:0] {StIdle, StDrive, StWait, StCheck} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [2:0]       retry_cnt_q, retry_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Bits whose current q differs from the latched target.
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] j_drive;
  logic [WIDTH-1:0] k_drive;

  assign diff = q_fb ^ tgt_q;

`ifdef JK_BANK_DRIVER_TOGGLE_EN
  assign j_drive = diff;
  assign k_drive = diff;
`else
  // Set bits that must rise, reset bits that must fall; j and k are never both high.
  assign j_drive = diff & tgt_q;
  assign k_drive = diff & ~tgt_q;
`endif

  always_comb begin
    state_d     = state_q;
    j_d         = '0;
    k_d         = '0;
    tgt_d       = tgt_q;
    retry_cnt_d = retry_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          tgt_d       = target;
          retry_cnt_d = '0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          state_d     = StDrive;
        end
      end
      StDrive: begin
        j_d     = j_drive;
        k_d     = k_drive;
        state_d = StWait;
      end
      StWait: begin
        // The bank samples the pulse at this edge; drop j/k back to hold.
        state_d = StCheck;
      end
      StCheck: begin
        if (diff == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (retry_cnt_q < MaxRetry) begin
          retry_cnt_d = retry_cnt_q + 3'd1;
          state_d     = StDrive;
        end else begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      j_q         <= '0;
      k_q         <= '0;
      tgt_q       <= '0;
      retry_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      k_q         <= k_d;
      tgt_q       <= tgt_d;
      retry_cnt_q <= retry_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign j    = j_q;
  assign k    = k_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: a behavioural JK bank closes the q feedback loop, a
// transaction-level model predicts every output each cycle, and directed sequences add
// hand-computed literal expectations.

module tb_jk_bank_driver;

  localparam int W  = 4;
  localparam int MR = 2;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] target;
  logic [W-1:0] q_fb;
  logic [W-1:0] j_o;
  logic [W-1:0] k_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;

  int n_tests = 0;
  int n_fail  = 0;

  jk_bank_driver #(
    .WIDTH     (W),
    .MAX_RETRY (MR)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .target (target),
    .q_fb   (q_fb),
    .j      (j_o),
    .k      (k_o),
    .busy   (busy_o),
    .done   (done_o),
    .err    (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK bank model with optional stuck-at-0 bits on its q outputs.
  logic [W-1:0] bank_q;
  logic         bank_load;
  logic [W-1:0] bank_val;
  logic [W-1:0] stuck;

  always @(posedge clk) begin
    if (bank_load) bank_q <= bank_val;
    else           bank_q <= (j_o & ~bank_q) | (~k_o & bank_q);
  end

  assign q_fb = bank_q & ~stuck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: counts edges since acceptance; every third edge starting
  // at 1 is a drive pulse, every third edge starting at 3 is a readback.
  logic         m_valid = 1'b0;
  logic         m_busy  = 1'b0;
  logic         m_done  = 1'b0;
  logic         m_err   = 1'b0;
  logic [W-1:0] m_j     = '0;
  logic [W-1:0] m_k     = '0;
  logic [W-1:0] m_tgt   = '0;
  int           m_age   = 0;

  initial forever begin
    logic [W-1:0] d;
    @(posedge clk);
    if (!reset) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_j     = '0;
      m_k     = '0;
    end else begin
      m_done = 1'b0;
      m_j    = '0;
      m_k    = '0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          m_tgt  = target;
          m_err  = 1'b0;
          m_age  = 0;
        end
      end else begin
        m_age++;
        d = q_fb ^ m_tgt;
        if (m_age % 3 == 1) begin
`ifdef JK_BANK_DRIVER_TOGGLE_EN
          m_j = d;
          m_k = d;
`else
          m_j = d & m_tgt;
          m_k = d & ~m_tgt;
`endif
        end else if (m_age % 3 == 0) begin
          if (d == '0) begin
            m_done = 1'b1;
            m_busy = 1'b0;
          end else if (m_age / 3 > MR) begin
            m_err  = 1'b1;
            m_done = 1'b1;
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("j", 32'(j_o), 32'(m_j));
      chk("k", 32'(k_o), 32'(m_k));
      chk("busy", 32'(busy_o), 32'(m_busy));
      chk("done", 32'(done_o), 32'(m_done));
      chk("err", 32'(err_o), 32'(m_err));
`ifndef JK_BANK_DRIVER_TOGGLE_EN
      chk("jk_exclusive", 32'(j_o & k_o), 32'd0);
`endif
    end
  end

  task automatic load_bank(input logic [W-1:0] v);
    bank_load = 1'b1;
    bank_val  = v;
    @(negedge clk);
    bank_load = 1'b0;
  endtask

  // Presents start for one edge; on return the request has been accepted (after T0).
  task automatic start_op(input logic [W-1:0] t);
    start  = 1'b1;
    target = t;
    @(negedge clk);
    start  = 1'b0;
    target = ~t;
    chk("busy_after_accept", 32'(busy_o), 32'd1);
  endtask

  initial begin
    int cnt;
    reset     = 1'b0;
    start     = 1'b1;
    target    = 4'hF;
    bank_load = 1'b0;
    bank_val  = '0;
    stuck     = '0;

    // Reset held with start high: everything stays quiet.
    repeat (2) begin
      @(negedge clk);
      chk("rst_j", 32'(j_o), 32'd0);
      chk("rst_k", 32'(k_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
    end
    reset = 1'b1;
    start = 1'b0;
    load_bank(4'b0000);
    repeat (2) begin
      @(negedge clk);
      chk("idle_after_rst", 32'(busy_o), 32'd0);
    end

    // Set load 0000 -> 1010.
    start_op(4'b1010);
    @(negedge clk);
`ifdef JK_BANK_DRIVER_TOGGLE_EN
    chk("set_j", 32'(j_o), 32'b1010);
    chk("set_k", 32'(k_o), 32'b1010);
`else
    chk("set_j", 32'(j_o), 32'b1010);
    chk("set_k", 32'(k_o), 32'b0000);
`endif
    @(negedge clk);
    chk("set_j_cleared", 32'(j_o), 32'd0);
    chk("set_bank", 32'(q_fb), 32'b1010);
    chk("set_no_early_done", 32'(done_o), 32'd0);
    @(negedge clk);
    chk("set_done", 32'(done_o), 32'd1);
    chk("set_err", 32'(err_o), 32'd0);
    chk("set_busy_low", 32'(busy_o), 32'd0);
    @(negedge clk);
    chk("set_done_pulse", 32'(done_o), 32'd0);

    // Reset load 1111 -> 0110, then an all-hold load of the same pattern.
    load_bank(4'b1111);
    start_op(4'b0110);
    @(negedge clk);
`ifdef JK_BANK_DRIVER_TOGGLE_EN
    chk("rst_load_j", 32'(j_o), 32'b1001);
`else
    chk("rst_load_j", 32'(j_o), 32'b0000);
`endif
    chk("rst_load_k", 32'(k_o), 32'b1001);
    repeat (2) @(negedge clk);
    chk("rst_load_done", 32'(done_o), 32'd1);
    chk("rst_load_bank", 32'(q_fb), 32'b0110);
    start_op(4'b0110);
    @(negedge clk);
    chk("hold_j", 32'(j_o), 32'd0);
    chk("hold_k", 32'(k_o), 32'd0);
    repeat (2) @(negedge clk);
    chk("hold_done", 32'(done_o), 32'd1);
    chk("hold_bank", 32'(q_fb), 32'b0110);

    // Bit 0 stuck at 0: three drive attempts, then err with done on cycle 9.
    stuck = 4'b0001;
    load_bank(4'b0000);
    start_op(4'b0001);
    cnt = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (j_o == 4'b0001) cnt++;
      if (c == 9) begin
        chk("retry_done", 32'(done_o), 32'd1);
        chk("retry_err", 32'(err_o), 32'd1);
      end else begin
        chk("retry_no_done", 32'(done_o), 32'd0);
      end
    end
    chk("retry_pulses", 32'(cnt), 32'd3);
    @(negedge clk);
    chk("err_sticky", 32'(err_o), 32'd1);
    stuck = 4'b0000;
    start_op(4'b0000);
    chk("err_cleared", 32'(err_o), 32'd0);
    repeat (3) @(negedge clk);
    chk("recover_done", 32'(done_o), 32'd1);
    chk("recover_err", 32'(err_o), 32'd0);
    chk("recover_bank", 32'(q_fb), 32'b0000);

    // start pulsed during WAIT is ignored.
    load_bank(4'b0000);
    start_op(4'b0011);
    @(negedge clk);
    start  = 1'b1;
    target = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    cnt   = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_o) cnt++;
    end
    chk("busy_one_done", 32'(cnt), 32'd1);
    chk("busy_bank", 32'(q_fb), 32'b0011);

    // Reset asserted during WAIT aborts without a done pulse.
    load_bank(4'b0000);
    start_op(4'b1100);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_j", 32'(j_o), 32'd0);
    chk("abort_k", 32'(k_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    reset = 1'b1;
    cnt   = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_o || busy_o) cnt++;
    end
    chk("abort_quiet", 32'(cnt), 32'd0);

`ifdef JK_BANK_DRIVER_TOGGLE_EN
    // Toggle encoding 0101 -> 1001.
    load_bank(4'b0101);
    start_op(4'b1001);
    @(negedge clk);
    chk("tog_j", 32'(j_o), 32'b1100);
    chk("tog_k", 32'(k_o), 32'b1100);
    repeat (2) @(negedge clk);
    chk("tog_done", 32'(done_o), 32'd1);
    chk("tog_bank", 32'(q_fb), 32'b1001);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
